// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RISC-V control FSM: state encoding,
// opcode constants, datapath select encodings and an immediate-format helper.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_LUI      = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  // Per-state control bundle; pc_update and branch combine into pc_write.
  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  // Immediate format for the datapath's extender, keyed off the same opcodes.
  function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
    logic [2:0] sel;
    sel = IMM_I;
    case (opcode)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      OP_LUI:    sel = IMM_U;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM for a multicycle RISC-V core with a unified memory:
// Moore outputs per state, with fetch/memread progress gated by mem_ready.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned TRAP_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = (TRAP_ON_ILLEGAL != 0) ? S_ILLEGAL : S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Reset masks every output combinationally, so strobes drop in the same cycle.
  always_comb begin
    ctrl = '0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          ctrl.adr_src    = 1'b0;
          ctrl.alu_src_a  = SRCA_PC;
          ctrl.alu_src_b  = SRCB_FOUR;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.result_src = RES_ALU;
          ctrl.ir_write   = mem_ready;
          ctrl.pc_update  = mem_ready;
        end
        S_DECODE: begin
          ctrl.alu_src_a = SRCA_OLDPC;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMADR: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_MEMREAD: begin
          ctrl.adr_src    = 1'b1;
          ctrl.result_src = RES_ALUOUT;
        end
        S_MEMWB: begin
          ctrl.result_src = RES_DATA;
          ctrl.reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          ctrl.adr_src    = 1'b1;
          ctrl.result_src = RES_ALUOUT;
          ctrl.mem_write  = 1'b1;
        end
        S_EXECR: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_RS2;
          ctrl.alu_op    = ALUOP_FUNC;
        end
        S_EXECI: begin
          ctrl.alu_src_a = SRCA_RS1;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_FUNC;
        end
        S_LUI: begin
          ctrl.alu_src_a = SRCA_ZERO;
          ctrl.alu_src_b = SRCB_IMM;
          ctrl.alu_op    = ALUOP_ADD;
        end
        S_ALUWB: begin
          ctrl.result_src = RES_ALUOUT;
          ctrl.reg_write  = 1'b1;
        end
        S_BRANCH: begin
          ctrl.alu_src_a  = SRCA_RS1;
          ctrl.alu_src_b  = SRCB_RS2;
          ctrl.alu_op     = ALUOP_SUB;
          ctrl.result_src = RES_ALUOUT;
          ctrl.branch     = 1'b1;
        end
        S_JAL: begin
          ctrl.alu_src_a  = SRCA_OLDPC;
          ctrl.alu_src_b  = SRCB_FOUR;
          ctrl.alu_op     = ALUOP_ADD;
          ctrl.result_src = RES_ALUOUT;
          ctrl.pc_update  = 1'b1;
        end
        S_ILLEGAL: ctrl.illegal = 1'b1;
        default:   ctrl = '0;
      endcase
    end
  end

  assign pc_write   = ctrl.pc_update | (ctrl.branch & zero);
  assign adr_src    = ctrl.adr_src;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_write  = ctrl.reg_write;
  assign result_src = ctrl.result_src;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign illegal    = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks instruction sequences cycle by
// cycle and compares the packed output word against hand-derived patterns.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [6:0] op;

  logic       pc_write1, adr_src1, mem_write1, ir_write1, reg_write1, illegal1;
  logic [1:0] result_src1, alu_src_a1, alu_src_b1, alu_op1;
  logic       pc_write0, adr_src0, mem_write0, ir_write0, reg_write0, illegal0;
  logic [1:0] result_src0, alu_src_a0, alu_src_b0, alu_op0;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op, illegal}
  logic [13:0] out1, out0;
  assign out1 = {pc_write1, adr_src1, mem_write1, ir_write1, reg_write1,
                 result_src1, alu_src_a1, alu_src_b1, alu_op1, illegal1};
  assign out0 = {pc_write0, adr_src0, mem_write0, ir_write0, reg_write0,
                 result_src0, alu_src_a0, alu_src_b0, alu_op0, illegal0};

  localparam logic [13:0] E_ZERO    = 14'b0_0_0_0_0_00_00_00_00_0;
  localparam logic [13:0] E_FETCH   = 14'b1_0_0_1_0_10_00_10_00_0;
  localparam logic [13:0] E_FSTALL  = 14'b0_0_0_0_0_10_00_10_00_0;
  localparam logic [13:0] E_DECODE  = 14'b0_0_0_0_0_00_01_01_00_0;
  localparam logic [13:0] E_MEMADR  = 14'b0_0_0_0_0_00_10_01_00_0;
  localparam logic [13:0] E_MEMREAD = 14'b0_1_0_0_0_00_00_00_00_0;
  localparam logic [13:0] E_MEMWB   = 14'b0_0_0_0_1_01_00_00_00_0;
  localparam logic [13:0] E_MEMWR   = 14'b0_1_1_0_0_00_00_00_00_0;
  localparam logic [13:0] E_EXECR   = 14'b0_0_0_0_0_00_10_00_10_0;
  localparam logic [13:0] E_EXECI   = 14'b0_0_0_0_0_00_10_01_10_0;
  localparam logic [13:0] E_LUI     = 14'b0_0_0_0_0_00_11_01_00_0;
  localparam logic [13:0] E_ALUWB   = 14'b0_0_0_0_1_00_00_00_00_0;
  localparam logic [13:0] E_BR1     = 14'b1_0_0_0_0_00_10_00_01_0;
  localparam logic [13:0] E_BR0     = 14'b0_0_0_0_0_00_10_00_01_0;
  localparam logic [13:0] E_JAL     = 14'b1_0_0_0_0_00_01_10_00_0;
  localparam logic [13:0] E_ILL     = 14'b0_0_0_0_0_00_00_00_00_1;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned mw_seen = 0;

  multicycle_control #(.TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write1), .adr_src(adr_src1), .mem_write(mem_write1),
    .ir_write(ir_write1), .reg_write(reg_write1), .result_src(result_src1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_op(alu_op1),
    .illegal(illegal1)
  );

  multicycle_control #(.TRAP_ON_ILLEGAL(0)) dut_notrap (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write0), .adr_src(adr_src0), .mem_write(mem_write0),
    .ir_write(ir_write0), .reg_write(reg_write0), .result_src(result_src0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_op(alu_op0),
    .illegal(illegal0)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic rst, input logic mr, input logic z, input logic [6:0] o);
    reset = rst; mem_ready = mr; zero = z; op = o;
    #2;
    mw_seen += int'(mem_write1);
  endtask

  task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic rst, input logic mr, input logic z, input logic [6:0] o,
                      input string tag, input logic [13:0] exp);
    drive(rst, mr, z, o);
    check(tag, out1, exp);
    tick();
  endtask

  initial begin
    step(1, 1, 0, LW, "reset_0", E_ZERO);
    step(1, 1, 0, LW, "reset_held_fetch", E_ZERO);

    step(0, 1, 0, LW, "lw_fetch", E_FETCH);
    step(0, 1, 0, LW, "lw_decode", E_DECODE);
    step(0, 1, 0, LW, "lw_memadr", E_MEMADR);
    step(0, 1, 0, LW, "lw_memread", E_MEMREAD);
    step(0, 1, 0, LW, "lw_memwb", E_MEMWB);

    step(0, 1, 0, BEQ, "beq1_fetch", E_FETCH);
    step(0, 1, 0, BEQ, "beq1_decode", E_DECODE);
    step(0, 1, 1, BEQ, "beq1_branch", E_BR1);
    step(0, 1, 0, BEQ, "beq0_fetch", E_FETCH);
    step(0, 1, 0, BEQ, "beq0_decode", E_DECODE);
    step(0, 1, 0, BEQ, "beq0_branch", E_BR0);

    for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, RT, "stall_fetch", E_FSTALL);
    step(0, 1, 0, RT, "stall_release_fetch", E_FETCH);
    step(0, 1, 0, RT, "r_decode", E_DECODE);
    step(0, 1, 0, BAD, "r_execr_op_ignored", E_EXECR);
    step(0, 1, 0, BAD, "r_aluwb", E_ALUWB);

    step(0, 1, 0, LW, "lws_fetch", E_FETCH);
    step(0, 1, 0, LW, "lws_decode", E_DECODE);
    step(0, 1, 0, LW, "lws_memadr", E_MEMADR);
    step(0, 0, 0, SW, "lws_memread_wait0", E_MEMREAD);
    step(0, 0, 0, SW, "lws_memread_wait1", E_MEMREAD);
    step(0, 1, 0, SW, "lws_memread_go", E_MEMREAD);
    step(0, 1, 0, SW, "lws_memwb", E_MEMWB);

    step(0, 1, 0, IT, "addi_fetch", E_FETCH);
    step(0, 1, 0, IT, "addi_decode", E_DECODE);
    step(0, 1, 0, IT, "addi_execi", E_EXECI);
    step(0, 1, 0, IT, "addi_aluwb", E_ALUWB);

    mw_seen = 0;
    step(0, 1, 0, SW, "sw_fetch", E_FETCH);
    step(0, 1, 0, SW, "sw_decode", E_DECODE);
    step(0, 1, 0, SW, "sw_memadr", E_MEMADR);
    step(0, 1, 0, SW, "sw_memwrite", E_MEMWR);
    step(0, 1, 0, LUI, "lui_fetch", E_FETCH);
    step(0, 1, 0, LUI, "lui_decode", E_DECODE);
    step(0, 1, 0, LUI, "lui_exec", E_LUI);
    step(0, 1, 0, LUI, "lui_aluwb", E_ALUWB);
    step(0, 1, 0, JAL, "jal_fetch", E_FETCH);
    step(0, 1, 0, JAL, "jal_decode", E_DECODE);
    step(0, 1, 0, JAL, "jal_exec", E_JAL);
    step(0, 1, 0, JAL, "jal_aluwb", E_ALUWB);
    checks++;
    assert (mw_seen == 1) passed++;
    else $error("FAIL mem_write_count observed=%0d expected=1", mw_seen);

    step(0, 1, 0, SW, "swr_fetch", E_FETCH);
    step(0, 1, 0, SW, "swr_decode", E_DECODE);
    step(0, 1, 0, SW, "swr_memadr", E_MEMADR);
    step(1, 1, 0, SW, "swr_reset_in_memwrite", E_ZERO);
    step(0, 1, 0, SW, "swr_after_reset_fetch", E_FETCH);

    step(0, 1, 0, BAD, "ill_decode", E_DECODE);
    drive(0, 1, 0, BAD);
    check("ill_trap_enter", out1, E_ILL);
    check("notrap_back_to_fetch", out0, E_FETCH);
    tick();
    for (int unsigned i = 0; i < 10; i++) step(0, i[0], i[1], LW, "ill_hold", E_ILL);
    drive(1, 1, 0, LW);
    check("ill_reset_trap", out1, E_ZERO);
    check("ill_reset_notrap", out0, E_ZERO);
    tick();
    drive(0, 1, 0, LW);
    check("ill_recover_trap", out1, E_FETCH);
    check("ill_recover_notrap", out0, E_FETCH);
    tick();
    step(0, 1, 0, LW, "ill_recover_decode", E_DECODE);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
